inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Program-counter and fetch-control stage sitting directly upstream of the instruction memory (11-bit word address, synchronous read, 1-cycle latency, read data held while its enable is low). It drives the memory enable and address, pairs each returned word with its PC, and presents a valid instruction to decode. It handles decode back-pressure, branch/jump redirects, and misaligned-PC faults.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
ADDR_W, 11, instruction-memory word-address width; imem_addr = pc[ADDR_W+1:2].

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
imem_en  out  1  instruction-memory read enable.
imem_addr  out  ADDR_W  instruction-memory word address.
imem_rdata  in  32  instruction word, valid the cycle after an enabled read.
stall  in  1  decode cannot accept; hold the current instruction.
redirect_valid  in  1  branch/jump taken; refetch from redirect_pc.
redirect_pc  in  32  redirect target byte address.
inst_valid  out  1  inst/inst_pc valid for decode.
inst  out  32  fetched instruction (= imem_rdata).
inst_pc  out  32  byte PC of inst.
err_valid  out  1  misaligned-PC fault; fetch halted.
err_pc  out  32  offending PC.
fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Registers: state {RUN, HALT}, fetch_pc (next PC to issue), req_valid_q/req_pc_q (read in flight), err_pc_q, fetch_count.
- Reset values: state=RUN, fetch_pc=RESET_PC, req_valid_q=0, req_pc_q=0, err_pc_q=0, fetch_count=0.
- Outputs while rst=1: imem_en=0, inst_valid=0, err_valid=0, fetch_count=0.
- Reset mid-operation: all in-flight fetches are discarded and no instruction is emitted. The first cycle after release issues RESET_PC, and the first inst_valid appears one cycle later.
- Combinational outputs: inst=imem_rdata, inst_pc=req_pc_q, inst_valid = req_valid_q & (state==RUN) & !redirect_valid, err_valid=(state==HALT), err_pc=err_pc_q.
- RUN, no redirect, stall=0:
  - If fetch_pc[1:0]!=0: imem_en=0, state->HALT, err_pc_q<=fetch_pc, req_valid_q<=0.
  - Otherwise: imem_en=1, imem_addr=fetch_pc[ADDR_W+1:2], req_valid_q<=1, req_pc_q<=fetch_pc, fetch_pc<=fetch_pc+4.
- RUN, no redirect, stall=1:
  - imem_en=0; fetch_pc, req_* and state hold.
  - Memory data holds, so inst/inst_pc/inst_valid remain stable until stall drops.
  - No internal buffering is required.
- Redirect (any state, priority over stall and HALT):
  - inst_valid=0 this cycle; the in-flight word is squashed.
  - If redirect_pc[1:0]==0: imem_en=1, imem_addr=redirect_pc[ADDR_W+1:2], req_valid_q<=1, req_pc_q<=redirect_pc, fetch_pc<=redirect_pc+4, state->RUN. The target instruction is valid the next cycle (1-cycle redirect penalty).
  - Else: imem_en=0, req_valid_q<=0, state->HALT, err_pc_q<=redirect_pc.
- HALT: imem_en=0, inst_valid=0, err_valid=1 until a redirect. stall is ignored.
- fetch_count increments by 1 on each cycle with inst_valid=1 & stall=0. It wraps modulo 2^32.
- PC arithmetic is 32-bit and wraps modulo 2^32. Word-address bits above ADDR_W+1 are ignored (memory aliases, no fault): PC 0x1FFC -> addr 2047, next PC 0x2000 -> addr 0.
- Simultaneous stall and redirect: the redirect is taken; the held instruction is dropped and not counted.
- imem_addr is don't-care when imem_en=0. It is driven from fetch_pc in that case to minimise toggling.

Test Plan:
- Reset release, RESET_PC=0, no stall -> imem_en=1 with addr 0,1,2,...; inst_valid rises 1 cycle after release; inst_pc 0x0,0x4,0x8 back-to-back; fetch_count=3 after 3 accepted.
- Stall 3 cycles while inst_pc=0x8 is valid -> imem_en=0 for those cycles; inst/inst_pc=0x8 unchanged; fetch_count unchanged; after release 0xC follows with no bubble.
- Redirect to 0x100 while 0x10 is in flight -> inst_valid=0 that cycle; imem_addr=0x40; next cycle inst_pc=0x100, then 0x104; 0x10 never counted.
- Redirect asserted together with stall -> redirect wins; the stalled instruction is dropped; target instruction is valid next cycle.
- Redirect to 0x102 -> imem_en=0, err_valid=1 and err_pc=0x102 from the next cycle with inst_valid=0; a later redirect to 0x200 clears err_valid and fetches 0x200.
- Fetch across PC 0x1FFC -> imem_addr 2047 then 0; inst_pc 0x1FFC then 0x2000; no fault. Assert rst during a stall -> all outputs low and the restart is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory, pairs returned words with their PC,
// and handles decode back-pressure, redirects and misaligned-PC faults.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              err_valid,
  output logic [31:0]       err_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        en_d;
  logic        accept;

  assign inst        = imem_rdata;
  assign inst_pc     = req_pc_q;
  assign inst_valid  = req_valid_q & (state_q == StRun) & ~redirect_valid;
  assign err_valid   = (state_q == StHalt);
  assign err_pc      = err_pc_q;
  assign fetch_count = fetch_count_q;
  assign accept      = inst_valid & ~stall;

  // Enable is masked during reset so no read is launched while state is being cleared.
  assign imem_en = en_d & ~rst;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    err_pc_d      = err_pc_q;
    en_d          = 1'b0;
    imem_addr     = fetch_pc_q[ADDR_W+1:2];
    fetch_count_d = fetch_count_q + {31'd0, accept};

    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        en_d        = 1'b1;
        imem_addr   = redirect_pc[ADDR_W+1:2];
        req_valid_d = 1'b1;
        req_pc_d    = redirect_pc;
        fetch_pc_d  = redirect_pc + 32'd4;
        state_d     = StRun;
      end else begin
        req_valid_d = 1'b0;
        err_pc_d    = redirect_pc;
        state_d     = StHalt;
      end
    end else if (state_q == StRun && !stall) begin
      if (fetch_pc_q[1:0] != 2'b00) begin
        req_valid_d = 1'b0;
        err_pc_d    = fetch_pc_q;
        state_d     = StHalt;
      end else begin
        en_d        = 1'b1;
        req_valid_d = 1'b1;
        req_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= 32'd0;
      err_pc_q      <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      err_pc_q      <= err_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random stall/redirect/reset traffic,
// checked against a program-order model of the instruction stream.
module tb_inst_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        err_valid;
  logic [31:0] err_pc;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] redir_q[$];

  inst_fetch_unit #(.RESET_PC(ResetPc), .ADDR_W(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .err_valid     (err_valid),
    .err_pc        (err_pc),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return ({21'd0, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous-read memory that holds its data while the enable is low.
  always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: exp_pc is the next PC decode should receive in program order.
  logic [31:0] exp_pc    = ResetPc;
  logic [31:0] exp_err   = 32'd0;
  logic [31:0] exp_cnt   = 32'd0;
  logic        primed    = 1'b0;
  logic        halted    = 1'b0;

  always @(negedge clk) begin
    logic [31:0] tgt;
    logic [31:0] nxt;
    if (rst) begin
      chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
      chk("rst_fetch_count", fetch_count, 32'd0);
      exp_pc  = ResetPc;
      exp_cnt = 32'd0;
      primed  = 1'b0;
      halted  = 1'b0;
    end else begin
      chk("fetch_count", fetch_count, exp_cnt);
      chk("err_valid", {31'd0, err_valid}, {31'd0, halted});
      if (halted) chk("err_pc", err_pc, exp_err);
      if (redirect_valid) begin
        tgt = (redir_q.size() != 0) ? redir_q.pop_front() : 32'hDEAD_BEEF;
        chk("redir_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_imem_en", {31'd0, imem_en}, {31'd0, tgt[1:0] == 2'b00});
        if (tgt[1:0] == 2'b00) begin
          chk("redir_addr", {21'd0, imem_addr}, {21'd0, tgt[12:2]});
          exp_pc = tgt;
          primed = 1'b1;
          halted = 1'b0;
        end else begin
          exp_err = tgt;
          primed  = 1'b0;
          halted  = 1'b1;
        end
      end else if (halted) begin
        chk("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_imem_en", {31'd0, imem_en}, 32'd0);
      end else begin
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, primed});
        if (inst_valid) begin
          chk("inst_pc", inst_pc, exp_pc);
          chk("inst", inst, mem_word(exp_pc[12:2]));
        end
        chk("imem_en", {31'd0, imem_en}, {31'd0, !stall});
        nxt = primed ? exp_pc + 32'd4 : exp_pc;
        if (imem_en) chk("imem_addr", {21'd0, imem_addr}, {21'd0, nxt[12:2]});
        if (!stall) begin
          if (primed) begin
            exp_cnt = exp_cnt + 32'd1;
            exp_pc  = exp_pc + 32'd4;
          end
          primed = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rv ? rpc : 32'h0;
    if (rv) redir_q.push_back(rpc);
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 10) return ($urandom & 32'h0000_3FFC) | 32'($urandom_range(1, 3));
    if (r < 20) return 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) << 2);
    if (r < 30) return 32'h0000_1FE0 + 32'($urandom_range(0, 7) << 2);
    return $urandom & 32'h0000_3FFC;
  endfunction

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Free run 0x0.. then a 3-cycle stall while 0x8 is presented.
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0100);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0300);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0102);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0200);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    // Alias across the top of the word-address space.
    cyc(1'b0, 1'b1, 32'h0000_1FF4);
    repeat (5) cyc(1'b0, 1'b0, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    do_reset(2);
    repeat (4) cyc(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset($urandom_range(1, 3));
      end else begin
        cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, rand_target());
      end
    end
    cyc(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("redir_queue_empty", redir_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
